// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - double-buffered parallel-to-serial converter feeding the sequence detector
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             word_start
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             accept;
    logic [WIDTH-1:0] shreg_shifted;

    // The holding register frees itself by transferring into shreg, so ready is purely registered.
    assign in_ready = !hold_full_q;
    assign accept   = in_valid && !hold_full_q;

    // Output end is the MSB or LSB; vacated positions fill with zero.
    assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg_q[WIDTH-1:1]};

    // Serial outputs decode from registers only; bit_out is forced low while idle.
    assign bit_valid  = (state_q == SHIFT);
    assign bit_out    = (state_q == SHIFT) && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
    assign word_start = (state_q == SHIFT) && (cnt_q == '0);

    // Next-state: accept into the hold register, then move held words into shreg at word boundaries.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;

        if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    shreg_d     = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != LAST) begin
                    shreg_d = shreg_shifted;
                    cnt_d   = cnt_q + 1'b1;
                end else if (hold_full_q) begin
                    // Reload on the last bit keeps the stream gapless.
                    shreg_d     = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                end else begin
                    shreg_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; asynchronous reset drops both the in-flight and the held word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
